// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC and the single-outstanding imem read handshake.
// Optional IFETCH_MISALIGN_TRAP_EN: ignore misaligned redirects and flag them.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        if_clk,
    input  logic        if_rst_n,
    input  logic        if_stall,
    input  logic        if_redirect,
    input  logic [31:0] if_redirect_pc,
    output logic        if_imem_req,
    output logic [31:0] if_imem_addr,
    input  logic        if_imem_rvalid,
    input  logic [31:0] if_imem_rdata,
    output logic [31:0] if_instr,
    output logic        if_ir_wr_en,
    output logic [31:0] if_instr_pc,
    output logic        if_misalign
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DELIVER,
        S_DRAIN
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic        w_redir;
    logic [31:0] w_tgt;

`ifdef IFETCH_MISALIGN_TRAP_EN
    logic r_misalign;

    // A misaligned target is dropped entirely; the FSM never sees it.
    assign w_redir = if_redirect & (if_redirect_pc[1:0] == 2'b00);
    assign w_tgt   = if_redirect_pc;

    always_ff @(posedge if_clk or negedge if_rst_n) begin
        if (!if_rst_n) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= if_redirect & (if_redirect_pc[1:0] != 2'b00);
        end
    end

    assign if_misalign = r_misalign;
`else
    assign w_redir     = if_redirect;
    assign w_tgt       = if_redirect_pc & 32'hFFFF_FFFC;
    assign if_misalign = 1'b0;
`endif

    assign if_imem_req  = (r_state == S_FETCH);
    assign if_imem_addr = r_pc;
    assign if_instr     = r_instr;
    assign if_instr_pc  = r_instr_pc;
    assign if_ir_wr_en  = (r_state == S_DELIVER) & ~if_stall & ~w_redir;

    always_ff @(posedge if_clk or negedge if_rst_n) begin
        if (!if_rst_n) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_instr    <= 32'h0;
            r_instr_pc <= RESET_PC;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_redir) r_pc <= w_tgt;
                    r_state <= S_FETCH;
                end
                S_FETCH: begin
                    if (w_redir) begin
                        r_pc    <= w_tgt;
                        r_state <= S_DRAIN;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_redir) begin
                        r_pc    <= w_tgt;
                        r_state <= if_imem_rvalid ? S_FETCH : S_DRAIN;
                    end else if (if_imem_rvalid) begin
                        r_instr    <= if_imem_rdata;
                        r_instr_pc <= r_pc;
                        r_state    <= S_DELIVER;
                    end
                end
                S_DELIVER: begin
                    if (w_redir) begin
                        r_pc    <= w_tgt;
                        r_state <= S_FETCH;
                    end else if (!if_stall) begin
                        r_pc    <= r_pc + 32'd4;
                        r_state <= S_FETCH;
                    end
                end
                S_DRAIN: begin
                    // Stale response is swallowed; newest redirect wins.
                    if (w_redir) r_pc <= w_tgt;
                    if (if_imem_rvalid) r_state <= S_FETCH;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a variable-latency memory model.
// Build with +define+IFETCH_MISALIGN_TRAP_EN to exercise the trap variant.
module tb_instruction_fetch;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        req;
    logic [31:0] addr;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic [31:0] instr;
    logic        wr_en;
    logic [31:0] instr_pc;
    logic        misalign;

    int n_pass = 0;
    int n_total = 0;
    int lat = 1;
    int cnt = 0;
    bit busy = 1'b0;
    logic [31:0] maddr = 32'h0;

    instruction_fetch dut (
        .if_clk         (clk),
        .if_rst_n       (rst_n),
        .if_stall       (stall),
        .if_redirect    (redirect),
        .if_redirect_pc (redirect_pc),
        .if_imem_req    (req),
        .if_imem_addr   (addr),
        .if_imem_rvalid (rvalid),
        .if_imem_rdata  (rdata),
        .if_instr       (instr),
        .if_ir_wr_en    (wr_en),
        .if_instr_pc    (instr_pc),
        .if_misalign    (misalign)
    );

    always #5 clk = ~clk;

    // Memory: response appears 'lat' cycles after the request cycle.
    always @(negedge clk) begin
        rvalid = 1'b0;
        if (!rst_n) begin
            busy = 1'b0;
        end else begin
            if (busy) begin
                if (cnt <= 1) begin
                    rvalid = 1'b1;
                    rdata  = maddr ^ K;
                    busy   = 1'b0;
                end else begin
                    cnt = cnt - 1;
                end
            end
            if (req) begin
                busy  = 1'b1;
                cnt   = lat;
                maddr = addr;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        n_total++;
        if (req !== 1'b0 || wr_en !== 1'b0 || misalign !== 1'b0)
            $display("FAIL reset_ctl: req=%b wr=%b mis=%b required 0 0 0", req, wr_en, misalign);
        else n_pass++;
        n_total++;
        if (addr !== 32'h0 || instr !== 32'h0 || instr_pc !== 32'h0)
            $display("FAIL reset_data: addr=%h instr=%h ipc=%h required 0", addr, instr, instr_pc);
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_sequential;
        int n = 0;
        lat = 1;
        while (!req && n < 20) begin tick(); n++; end
        n_total++;
        if (n !== 1) $display("FAIL first_req_latency: %0d cycles required 1", n);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (req !== 1'b1 || addr !== 32'(4 * i))
                $display("FAIL seq_req%0d: req=%b addr=%h required 1 %h", i, req, addr, 32'(4 * i));
            else n_pass++;
            tick();
            tick();
            n_total++;
            if (wr_en !== 1'b1 || instr !== (K | 32'(4 * i)) || instr_pc !== 32'(4 * i))
                $display("FAIL seq_deliver%0d: wr=%b instr=%h ipc=%h required 1 %h %h",
                         i, wr_en, instr, instr_pc, K | 32'(4 * i), 32'(4 * i));
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_stall;
        n_total++;
        if (req !== 1'b1 || addr !== 32'hC) $display("FAIL stall_req: addr=%h required c", addr);
        else n_pass++;
        tick();
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_total++;
            if (wr_en !== 1'b0 || req !== 1'b0 || instr !== 32'hA5A5_000C || instr_pc !== 32'hC)
                $display("FAIL stall_hold%0d: wr=%b req=%b instr=%h ipc=%h required 0 0 a5a5000c c",
                         i, wr_en, req, instr, instr_pc);
            else n_pass++;
        end
        stall = 1'b0;
        #1;
        n_total++;
        if (wr_en !== 1'b1) $display("FAIL stall_release: wr=%b required 1", wr_en);
        else n_pass++;
        tick();
        n_total++;
        if (req !== 1'b1 || addr !== 32'h10) $display("FAIL stall_next: addr=%h required 10", addr);
        else n_pass++;
    endtask

    task automatic test_redirect_wait;
        int n = 0;
        bit saw_wr = 1'b0;
        lat = 3;
        tick();
        redirect = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        while (!req && n < 20) begin
            if (wr_en) saw_wr = 1'b1;
            tick();
            n++;
        end
        n_total++;
        if (saw_wr !== 1'b0) $display("FAIL drain_wr: saw wr_en=%b required 0", saw_wr);
        else n_pass++;
        n_total++;
        if (req !== 1'b1 || addr !== 32'h100 || n !== 2)
            $display("FAIL drain_next: req=%b addr=%h after %0d required 1 100 after 2", req, addr, n);
        else n_pass++;
    endtask

    task automatic test_redirect_rvalid;
        lat = 1;
        tick();
        redirect = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        n_total++;
        if (req !== 1'b1 || addr !== 32'h200 || instr !== 32'hA5A5_000C)
            $display("FAIL redir_rvalid: req=%b addr=%h instr=%h required 1 200 a5a5000c", req, addr, instr);
        else n_pass++;
    endtask

    task automatic test_redirect_deliver_stall;
        tick();
        stall = 1'b1;
        tick();
        n_total++;
        if (wr_en !== 1'b0 || instr !== 32'hA5A5_0200)
            $display("FAIL deliv_stall: wr=%b instr=%h required 0 a5a50200", wr_en, instr);
        else n_pass++;
        redirect = 1'b1;
        redirect_pc = 32'h300;
        stall = 1'b0;
        #1;
        n_total++;
        if (wr_en !== 1'b0) $display("FAIL deliv_redir_wr: wr=%b required 0", wr_en);
        else n_pass++;
        tick();
        redirect = 1'b0;
        n_total++;
        if (req !== 1'b1 || addr !== 32'h300) $display("FAIL deliv_redir_next: addr=%h required 300", addr);
        else n_pass++;
    endtask

    task automatic test_wrap;
        tick();
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        n_total++;
        if (req !== 1'b1 || addr !== 32'hFFFF_FFFC) $display("FAIL wrap_req: addr=%h required fffffffc", addr);
        else n_pass++;
        tick();
        tick();
        n_total++;
        if (wr_en !== 1'b1 || instr !== 32'h5A5A_FFFC || instr_pc !== 32'hFFFF_FFFC)
            $display("FAIL wrap_deliver: wr=%b instr=%h ipc=%h required 1 5a5afffc fffffffc", wr_en, instr, instr_pc);
        else n_pass++;
        tick();
        n_total++;
        if (req !== 1'b1 || addr !== 32'h0) $display("FAIL wrap_next: addr=%h required 0", addr);
        else n_pass++;
    endtask

    task automatic test_redirect_fetch_and_reset;
        redirect = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        n_total++;
        if (req !== 1'b0) $display("FAIL fetch_redir_drain: req=%b required 0", req);
        else n_pass++;
        lat = 3;
        tick();
        n_total++;
        if (req !== 1'b1 || addr !== 32'h40) $display("FAIL fetch_redir_next: addr=%h required 40", addr);
        else n_pass++;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (req !== 1'b0 || wr_en !== 1'b0 || addr !== 32'h0 || instr !== 32'h0 || instr_pc !== 32'h0)
            $display("FAIL async_reset: req=%b wr=%b addr=%h instr=%h ipc=%h required 0", req, wr_en, addr, instr, instr_pc);
        else n_pass++;
        tick();
        rst_n = 1'b1;
        lat = 1;
        tick();
        n_total++;
        if (req !== 1'b1 || addr !== 32'h0) $display("FAIL post_reset_req: req=%b addr=%h required 1 0", req, addr);
        else n_pass++;
    endtask

    task automatic test_misalign;
        tick();
        redirect = 1'b1;
        redirect_pc = 32'h102;
        tick();
        redirect = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
        n_total++;
        if (misalign !== 1'b1 || wr_en !== 1'b1 || instr !== K)
            $display("FAIL mis_ignored: mis=%b wr=%b instr=%h required 1 1 %h", misalign, wr_en, instr, K);
        else n_pass++;
        tick();
        n_total++;
        if (misalign !== 1'b0 || req !== 1'b1 || addr !== 32'h4)
            $display("FAIL mis_after: mis=%b req=%b addr=%h required 0 1 4", misalign, req, addr);
        else n_pass++;
`else
        n_total++;
        if (misalign !== 1'b0 || req !== 1'b1 || addr !== 32'h100)
            $display("FAIL mis_forced: mis=%b req=%b addr=%h required 0 1 100", misalign, req, addr);
        else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_rvalid();
        test_redirect_deliver_stall();
        test_wrap();
        test_redirect_fetch_and_reset();
        test_misalign();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
